// File: rtl/axis_governor_mc.sv
// AXI-Stream governor: pause/drop/log passthrough plus boundary-safe packet injection.
// Optional statistics counters enabled by defining AXIS_GOVERNOR_STATS_EN.
module axis_governor_mc #(
  parameter int         DATA_WIDTH = 64,
  parameter int         DEST_WIDTH = 8,
  parameter int         ID_WIDTH   = 8,
  parameter logic [7:0] CMD_ADDR   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_TDATA,
  input  logic                    in_TVALID,
  output logic                    in_TREADY,
  input  logic [DATA_WIDTH/8-1:0] in_TKEEP,
  input  logic [DEST_WIDTH-1:0]   in_TDEST,
  input  logic [ID_WIDTH-1:0]     in_TID,
  input  logic                    in_TLAST,
  input  logic [DATA_WIDTH-1:0]   cmd_TDATA,
  input  logic                    cmd_TVALID,
  output logic                    cmd_TREADY,
  output logic [DATA_WIDTH-1:0]   out_TDATA,
  output logic                    out_TVALID,
  input  logic                    out_TREADY,
  output logic [DATA_WIDTH/8-1:0] out_TKEEP,
  output logic [DEST_WIDTH-1:0]   out_TDEST,
  output logic [ID_WIDTH-1:0]     out_TID,
  output logic                    out_TLAST,
  output logic [DATA_WIDTH-1:0]   log_TDATA,
  output logic                    log_TVALID,
  input  logic                    log_TREADY,
  output logic [DATA_WIDTH/8-1:0] log_TKEEP,
  output logic [DEST_WIDTH-1:0]   log_TDEST,
  output logic [ID_WIDTH-1:0]     log_TID,
`ifdef AXIS_GOVERNOR_STATS_EN
  output logic [31:0]             stat_flits,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_drops,
`endif
  output logic                    log_TLAST
);

  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_INJECT
  } state_t;

  state_t                state;
  logic                  pause_q;
  logic                  drop_q;
  logic                  log_q;
  logic                  mid_pkt;
  logic [15:0]           cnt;
  logic [DEST_WIDTH-1:0] inj_dest;
  logic [ID_WIDTH-1:0]   inj_id;

  logic        addr_hit;
  logic        hdr_acc;
  logic        hdr_inj;
  logic [15:0] hdr_n;
  logic        in_xfer;
  logic        cmd_xfer;
  logic        inj_go;
  logic        log_ok;
  logic        unused_cmd;

  assign addr_hit   = cmd_TDATA[63:56] == CMD_ADDR;
  assign hdr_n      = cmd_TDATA[31:16];
  assign hdr_acc    = (state == S_IDLE) && addr_hit && cmd_TVALID && !rst;
  assign hdr_inj    = hdr_acc && cmd_TDATA[0] && (hdr_n != 16'd0);
  assign in_xfer    = in_TVALID && in_TREADY;
  assign cmd_xfer   = cmd_TVALID && cmd_TREADY;
  assign inj_go     = !mid_pkt && !in_xfer;
  assign log_ok     = log_q ? log_TREADY : 1'b1;
  assign unused_cmd = ^cmd_TDATA;

  assign log_TDATA  = in_TDATA;
  assign log_TKEEP  = in_TKEEP;
  assign log_TDEST  = in_TDEST;
  assign log_TID    = in_TID;
  assign log_TLAST  = in_TLAST;

  // Handshake steering and output mux; passthrough has zero latency.
  always_comb begin
    in_TREADY  = 1'b0;
    out_TVALID = 1'b0;
    log_TVALID = 1'b0;
    cmd_TREADY = 1'b0;
    out_TDATA  = in_TDATA;
    out_TKEEP  = in_TKEEP;
    out_TDEST  = in_TDEST;
    out_TID    = in_TID;
    out_TLAST  = in_TLAST;
    if (rst) begin
      in_TREADY = 1'b0;
    end else if (state == S_INJECT) begin
      out_TDATA  = cmd_TDATA;
      out_TVALID = cmd_TVALID;
      cmd_TREADY = out_TREADY;
      out_TKEEP  = {KW{1'b1}};
      out_TDEST  = inj_dest;
      out_TID    = inj_id;
      out_TLAST  = cnt == 16'd1;
    end else if (state == S_WAIT && !mid_pkt) begin
      // boundary reached: hold input for the hand-over cycle
      in_TREADY = 1'b0;
    end else begin
      if (pause_q) begin
        in_TREADY = 1'b0;
      end else if (drop_q) begin
        in_TREADY = log_ok;
      end else begin
        in_TREADY  = out_TREADY && log_ok;
        out_TVALID = in_TVALID && log_ok;
      end
      log_TVALID = log_q && in_TVALID && in_TREADY;
      cmd_TREADY = (state == S_IDLE) && addr_hit;
    end
  end

  // Mode registers, packet tracking and injection FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pause_q  <= 1'b1;
      drop_q   <= 1'b0;
      log_q    <= 1'b0;
      mid_pkt  <= 1'b0;
      cnt      <= 16'd0;
      inj_dest <= '0;
      inj_id   <= '0;
    end else begin
      if (in_xfer) mid_pkt <= !in_TLAST;
      unique case (state)
        S_IDLE: begin
          if (hdr_acc) begin
            pause_q <= cmd_TDATA[3];
            drop_q  <= cmd_TDATA[2];
            log_q   <= cmd_TDATA[1];
          end
          if (hdr_inj) begin
            cnt      <= hdr_n;
            inj_dest <= cmd_TDATA[48 +: DEST_WIDTH];
            inj_id   <= cmd_TDATA[40 +: ID_WIDTH];
            state    <= inj_go ? S_INJECT : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mid_pkt) state <= S_INJECT;
        end
        S_INJECT: begin
          if (cmd_xfer) begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXIS_GOVERNOR_STATS_EN
  // Passthrough and drop counters; a clear header wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || (hdr_acc && cmd_TDATA[4])) begin
      stat_flits <= 32'd0;
      stat_pkts  <= 32'd0;
      stat_drops <= 32'd0;
    end else if (in_xfer) begin
      if (drop_q) begin
        stat_drops <= stat_drops + 32'd1;
      end else begin
        stat_flits <= stat_flits + 32'd1;
        if (in_TLAST) stat_pkts <= stat_pkts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_governor_mc.sv
// Directed bench for axis_governor_mc.
// Stats checks run when AXIS_GOVERNOR_STATS_EN is defined.
module tb_axis_governor_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_TDATA = '0;
  logic        in_TVALID = 1'b0;
  logic        in_TREADY;
  logic [7:0]  in_TKEEP = 8'hFF;
  logic [7:0]  in_TDEST = '0;
  logic [7:0]  in_TID = '0;
  logic        in_TLAST = 1'b0;
  logic [63:0] cmd_TDATA = '0;
  logic        cmd_TVALID = 1'b0;
  logic        cmd_TREADY;
  logic [63:0] out_TDATA;
  logic        out_TVALID;
  logic        out_TREADY = 1'b0;
  logic [7:0]  out_TKEEP;
  logic [7:0]  out_TDEST;
  logic [7:0]  out_TID;
  logic        out_TLAST;
  logic [63:0] log_TDATA;
  logic        log_TVALID;
  logic        log_TREADY = 1'b0;
  logic [7:0]  log_TKEEP;
  logic [7:0]  log_TDEST;
  logic [7:0]  log_TID;
  logic        log_TLAST;
`ifdef AXIS_GOVERNOR_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_pkts;
  logic [31:0] stat_drops;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_governor_mc dut (
    .clk(clk), .rst(rst),
    .in_TDATA(in_TDATA), .in_TVALID(in_TVALID),
    .in_TREADY(in_TREADY), .in_TKEEP(in_TKEEP),
    .in_TDEST(in_TDEST), .in_TID(in_TID),
    .in_TLAST(in_TLAST),
    .cmd_TDATA(cmd_TDATA), .cmd_TVALID(cmd_TVALID),
    .cmd_TREADY(cmd_TREADY),
    .out_TDATA(out_TDATA), .out_TVALID(out_TVALID),
    .out_TREADY(out_TREADY), .out_TKEEP(out_TKEEP),
    .out_TDEST(out_TDEST), .out_TID(out_TID),
    .out_TLAST(out_TLAST),
    .log_TDATA(log_TDATA), .log_TVALID(log_TVALID),
    .log_TREADY(log_TREADY), .log_TKEEP(log_TKEEP),
    .log_TDEST(log_TDEST), .log_TID(log_TID),
`ifdef AXIS_GOVERNOR_STATS_EN
    .stat_flits(stat_flits), .stat_pkts(stat_pkts),
    .stat_drops(stat_drops),
`endif
    .log_TLAST(log_TLAST)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [63:0] w);
    int n;
    n = 0;
    cmd_TDATA  = w;
    cmd_TVALID = 1'b1;
    #1;
    while (!cmd_TREADY && n < 20) begin
      tick();
      n++;
    end
    chk("hdr_rdy", cmd_TREADY, 1);
    tick();
    cmd_TVALID = 1'b0;
    cmd_TDATA  = 64'h0100_0000_0000_0000;
  endtask

  logic [63:0] f2 [4];
  logic [63:0] f4 [5];
  logic [63:0] pl [2];
  int k, cyc, seen;

  initial begin
    f2 = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
           64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
    f4 = '{64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'hC4};
    pl = '{64'hA5A5_0000_DEAD_BEEF, 64'h0000_0000_CAFE_F00D};

    // reset: everything held off
    in_TVALID  = 1'b1;
    cmd_TVALID = 1'b1;
    out_TREADY = 1'b1;
    log_TREADY = 1'b1;
    tick();
    tick();
    chk("rst_irdy", in_TREADY, 0);
    chk("rst_ovld", out_TVALID, 0);
    chk("rst_lvld", log_TVALID, 0);
    chk("rst_crdy", cmd_TREADY, 0);
    cmd_TVALID = 1'b0;
    rst = 1'b0;

    // paused after reset
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (in_TREADY || out_TVALID) seen++;
    end
    chk("t1_paused", seen, 0);

    // wrong address is never consumed
    cmd_TDATA  = 64'h0100_0000_0000_0000;
    cmd_TVALID = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cmd_TREADY) seen++;
    end
    chk("t5_crdy", seen, 0);
    chk("t5_still_paused", in_TREADY, 0);
    cmd_TVALID = 1'b0;
    in_TVALID  = 1'b0;

    // unpause, 4 flits, out_TREADY 1010
    send_hdr(64'h0);
    k = 0;
    cyc = 0;
    in_TVALID = 1'b1;
    while (k < 4 && cyc < 20) begin
      in_TDATA   = f2[k];
      in_TLAST   = (k == 3);
      out_TREADY = (cyc % 2 == 0);
      #1;
      chk("t2_irdy", in_TREADY, out_TREADY);
      if (out_TREADY) begin
        chk("t2_ovld", out_TVALID, 1);
        chk("t2_data", out_TDATA, f2[k]);
        chk("t2_last", out_TLAST, (k == 3));
        k++;
      end
      tick();
      cyc++;
    end
    chk("t2_count", k, 4);
    in_TVALID  = 1'b0;
    out_TREADY = 1'b1;

    // drop + log
    send_hdr(64'h6);
    log_TREADY = 1'b1;
    in_TVALID  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_TDATA = 64'hD0 + 64'(i);
      in_TLAST = (i == 2);
      #1;
      chk("t3_ovld", out_TVALID, 0);
      chk("t3_lvld", log_TVALID, 1);
      chk("t3_ldata", log_TDATA, 64'hD0 + 64'(i));
      tick();
    end
    log_TREADY = 1'b0;
    #1;
    chk("t3_irdy_blk", in_TREADY, 0);
    chk("t3_lvld_blk", log_TVALID, 0);
    in_TVALID  = 1'b0;
    log_TREADY = 1'b1;

    // inject with N=0 is ignored, modes applied
    send_hdr(64'h1);
    in_TVALID = 1'b1;
    in_TDATA  = 64'h77;
    in_TLAST  = 1'b1;
    #1;
    chk("n0_irdy", in_TREADY, 1);
    chk("n0_data", out_TDATA, 64'h77);
    tick();
    in_TVALID = 1'b0;

    // inject in the middle of a packet
    in_TDEST = 8'h05;
    in_TID   = 8'h06;
    in_TVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_TDATA = f4[i];
      in_TLAST = 1'b0;
      #1;
      chk("t4_pre", out_TVALID, 1);
      tick();
    end
    in_TVALID = 1'b0;
    send_hdr(64'h0012_3400_0002_0001);
    in_TVALID = 1'b1;
    for (int i = 2; i < 5; i++) begin
      in_TDATA = f4[i];
      in_TLAST = (i == 4);
      #1;
      chk("t4_pvld", out_TVALID, 1);
      chk("t4_pdata", out_TDATA, f4[i]);
      chk("t4_pdest", out_TDEST, 8'h05);
      chk("t4_plast", out_TLAST, (i == 4));
      tick();
    end
    in_TDATA = 64'h99;
    in_TLAST = 1'b1;
    for (int w = 0; w < 2; w++) begin
      cmd_TDATA  = pl[w];
      cmd_TVALID = 1'b1;
      n_wait(w);
      chk("t4_ivld", out_TVALID, 1);
      chk("t4_idata", out_TDATA, pl[w]);
      chk("t4_idest", out_TDEST, 8'h12);
      chk("t4_iid", out_TID, 8'h34);
      chk("t4_ikeep", out_TKEEP, 8'hFF);
      chk("t4_ilast", out_TLAST, (w == 1));
      chk("t4_iblk", in_TREADY, 0);
      chk("t4_lblk", log_TVALID, 0);
      tick();
    end
    cmd_TVALID = 1'b0;
    cmd_TDATA  = 64'h0100_0000_0000_0000;
    #1;
    chk("t4_resume", in_TREADY, 1);
    chk("t4_rdata", out_TDATA, 64'h99);
    tick();
    in_TVALID = 1'b0;

`ifdef AXIS_GOVERNOR_STATS_EN
    send_hdr(64'h10);
    chk("t6_clr0", stat_flits, 0);
    in_TVALID = 1'b1;
    for (int p = 0; p < 10; p++) begin
      for (int q = 0; q < 3; q++) begin
        in_TDATA = 64'(p * 3 + q);
        in_TLAST = (q == 2);
        tick();
      end
    end
    in_TVALID = 1'b0;
    chk("t6_flits", stat_flits, 30);
    chk("t6_pkts", stat_pkts, 10);
    send_hdr(64'h4);
    in_TVALID = 1'b1;
    tick();
    tick();
    in_TVALID = 1'b0;
    chk("t6_drops", stat_drops, 2);
    chk("t6_flits_hold", stat_flits, 30);
    send_hdr(64'h10);
    chk("t6_cf", stat_flits, 0);
    chk("t6_cp", stat_pkts, 0);
    chk("t6_cd", stat_drops, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic n_wait(input int w);
    int n;
    n = 0;
    #1;
    while (!(out_TVALID && cmd_TREADY) && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("t4_wait%0d", w), (n < 10), 1);
  endtask

endmodule
